// File: rtl/supercar_pkg.sv
// Shared widths and speed arithmetic for the Supercar scanner.
package supercar_pkg;

    localparam int unsigned SPEED_W = 4;
    localparam int unsigned POS_W   = 4;
    localparam int unsigned LIM_W   = SPEED_W + 1;
    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(15);

    // Base ticks per step: 16 at speed 0 down to 1 at speed 15.
    function automatic logic [LIM_W-1:0] speed_limit(input logic [SPEED_W-1:0] spd);
        return LIM_W'(16) - {1'b0, spd};
    endfunction

endpackage

// File: rtl/button_edge.sv
// Two-flop synchroniser for an asynchronous button level plus a rising-edge pulse.
module button_edge (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic btn,
    output logic rise_c
);

    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            prev <= sync[1];
        end
    end

    assign rise_c = sync[1] & ~prev;

endmodule

// File: rtl/supercar_scanner.sv
// Bouncing one-hot LED sweep with button-adjustable speed and run enable.
module supercar_scanner
    import supercar_pkg::*;
#(
    parameter int unsigned N_LEDS     = 10,
    parameter int unsigned TICK_DIV   = 2_500_000,
    parameter int unsigned SPEED_INIT = 8
) (
    input  logic               CLOCK_50,
    input  logic               rst,
    input  logic               en,
    input  logic               spd_up,
    input  logic               spd_dn,
    output logic [N_LEDS-1:0]  LEDR,
    output logic [POS_W-1:0]   pos,
    output logic [SPEED_W-1:0] speed,
    output logic               dir,
    output logic               step
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0]   base_cnt;
    logic [LIM_W-1:0]   step_cnt;
    logic               up_rise_c;
    logic               dn_rise_c;
    logic               base_tick_c;
    logic               last_tick_c;
    logic               speed_chg_c;
    logic [SPEED_W-1:0] speed_nxt_c;
    logic [POS_W-1:0]   next_pos_c;

    button_edge u_up (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .btn      (spd_up),
        .rise_c   (up_rise_c)
    );

    button_edge u_dn (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .btn      (spd_dn),
        .rise_c   (dn_rise_c)
    );

    // Speed update and step timing; a real speed change restarts the step count.
    always_comb begin
        speed_nxt_c = speed;
        if (up_rise_c && !dn_rise_c && (speed != SPEED_MAX)) begin
            speed_nxt_c = speed + SPEED_W'(1);
        end else if (dn_rise_c && !up_rise_c && (speed != '0)) begin
            speed_nxt_c = speed - SPEED_W'(1);
        end
        speed_chg_c = (speed_nxt_c != speed);
        base_tick_c = en && (base_cnt == CNT_W'(TICK_DIV - 1));
        last_tick_c = base_tick_c && !speed_chg_c &&
                      (step_cnt == (speed_limit(speed) - LIM_W'(1)));
        next_pos_c  = dir ? (pos - POS_W'(1)) : (pos + POS_W'(1));
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            base_cnt <= '0;
            step_cnt <= '0;
            speed    <= SPEED_W'(SPEED_INIT);
            pos      <= '0;
            LEDR     <= N_LEDS'(1);
            dir      <= 1'b0;
            step     <= 1'b0;
        end else begin
            speed <= speed_nxt_c;
            step  <= last_tick_c;

            if (en) begin
                base_cnt <= base_tick_c ? '0 : base_cnt + CNT_W'(1);
            end

            if (speed_chg_c) begin
                step_cnt <= '0;
            end else if (base_tick_c) begin
                step_cnt <= last_tick_c ? '0 : step_cnt + LIM_W'(1);
            end

            // Direction flips on the edge that lands on either end of the bar.
            if (last_tick_c) begin
                pos  <= next_pos_c;
                LEDR <= N_LEDS'(1) << next_pos_c;
                if ((next_pos_c == POS_W'(N_LEDS - 1)) || (next_pos_c == '0)) begin
                    dir <= ~dir;
                end
            end
        end
    end

endmodule

// File: tb/tb_supercar_scanner.sv
// Self-checking bench: behavioural sweep model plus directed and random stimulus.
module tb_supercar_scanner;

    localparam int N  = 4;
    localparam int TD = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         spd_up = 1'b0;
    logic         spd_dn = 1'b0;
    logic [N-1:0] LEDR;
    logic [3:0]   pos;
    logic [3:0]   speed;
    logic         dir;
    logic         step;

    int checks = 0;
    int errors = 0;

    // Model state: speed, enabled-cycle count, ticks since last step, steps taken.
    int       m_speed = 8;
    int       m_ecnt  = 0;
    int       m_ticks = 0;
    int       m_k     = 0;
    int       m_step  = 0;
    bit [2:0] uh = '0;
    bit [2:0] dh = '0;

    int exp_pos[7] = '{1, 2, 3, 2, 1, 0, 1};
    int exp_dir[7] = '{0, 0, 1, 1, 1, 0, 0};

    always #5 clk = ~clk;

    supercar_scanner #(
        .N_LEDS     (N),
        .TICK_DIV   (TD),
        .SPEED_INIT (8)
    ) dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .en       (en),
        .spd_up   (spd_up),
        .spd_dn   (spd_dn),
        .LEDR     (LEDR),
        .pos      (pos),
        .speed    (speed),
        .dir      (dir),
        .step     (step)
    );

    function automatic int tri_pos(input int k);
        int p = 2 * (N - 1);
        int m = k % p;
        return (m < N) ? m : p - m;
    endfunction

    function automatic int tri_dir(input int k);
        int m = k % (2 * (N - 1));
        return (m >= N - 1) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: button edges seen two samples late, steps after (16-speed) base ticks.
    initial forever begin
        int  nspd;
        bit  up_e;
        bit  dn_e;
        bit  tick;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_speed = 8; m_ecnt = 0; m_ticks = 0; m_k = 0; m_step = 0;
            uh = '0; dh = '0;
        end else begin
            up_e = uh[1] & ~uh[2];
            dn_e = dh[1] & ~dh[2];
            nspd = m_speed;
            if (up_e && !dn_e) nspd = (m_speed < 15) ? m_speed + 1 : 15;
            if (dn_e && !up_e) nspd = (m_speed > 0) ? m_speed - 1 : 0;
            tick = 1'b0;
            if (en) begin
                m_ecnt++;
                tick = ((m_ecnt % TD) == 0);
            end
            m_step = 0;
            if (nspd != m_speed) begin
                m_ticks = 0;
            end else if (tick) begin
                m_ticks++;
                if (m_ticks == 16 - m_speed) begin
                    m_ticks = 0;
                    m_k++;
                    m_step = 1;
                end
            end
            m_speed = nspd;
            uh = {uh[1:0], spd_up};
            dh = {dh[1:0], spd_dn};
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("ledr",  int'(LEDR),  1 << tri_pos(m_k));
        check("pos",   int'(pos),   tri_pos(m_k));
        check("dir",   int'(dir),   tri_dir(m_k));
        check("speed", int'(speed), m_speed);
        check("step",  int'(step),  m_step);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit up);
        @(negedge clk); #1;
        if (up) spd_up = 1'b1; else spd_dn = 1'b1;
        cycles(2); #1;
        spd_up = 1'b0; spd_dn = 1'b0;
        cycles(2);
    endtask

    task automatic wait_step(input int max, output int n);
        n = 0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (step) return;
        end
        checks++; errors++;
        $display("FAIL step_timeout: got no step within %0d cycles", n);
    endtask

    task automatic wait_pos(input int p, input int d, input int max);
        int n = 0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (step && pos == 4'(p) && dir == 1'(d)) return;
        end
        checks++; errors++;
        $display("FAIL pos_timeout: got no step to pos %0d dir %0d within %0d cycles", p, d, n);
    endtask

    // Asynchronous reset between edges, checked before any clock edge can act.
    task automatic async_reset(input string tag);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check({tag, "_ledr"},  int'(LEDR),  1);
        check({tag, "_pos"},   int'(pos),   0);
        check({tag, "_dir"},   int'(dir),   0);
        check({tag, "_speed"}, int'(speed), 8);
        check({tag, "_step"},  int'(step),  0);
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        #1;
        check("rst0_ledr",  int'(LEDR),  1);
        check("rst0_pos",   int'(pos),   0);
        check("rst0_speed", int'(speed), 8);
        @(negedge clk); #1;
        rst = 1'b0;
        en  = 1'b1;
        wait_step(40, n);
        check("first_step_latency", n, 16);
        check("first_step_pos", int'(pos), 1);

        // Sweep at speed 14: period 4 cycles.
        en = 1'b0;
        async_reset("rst_sweep");
        repeat (6) press(1'b1);
        check("speed14", int'(speed), 14);
        @(negedge clk); #1;
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_step(20, n);
            check("sweep_period", n, 4);
            check("sweep_pos", int'(pos), exp_pos[i]);
            check("sweep_dir", int'(dir), exp_dir[i]);
            check("sweep_ledr", int'(LEDR), 1 << exp_pos[i]);
        end

        // Saturation both ways, presses accepted with en=0.
        en = 1'b0;
        async_reset("rst_sat");
        repeat (10) press(1'b1);
        check("sat_hi", int'(speed), 15);
        @(negedge clk); #1;
        en = 1'b1;
        wait_step(40, n);
        wait_step(40, n);
        check("period_speed15", n, 2);
        en = 1'b0;
        repeat (20) press(1'b0);
        check("sat_lo", int'(speed), 0);
        @(negedge clk); #1;
        en = 1'b1;
        wait_step(80, n);
        wait_step(80, n);
        check("period_speed0", n, 32);

        // Simultaneous edges leave speed and step timing untouched.
        en = 1'b0;
        repeat (5) press(1'b1);
        check("speed5", int'(speed), 5);
        @(negedge clk); #1;
        en = 1'b1;
        wait_step(80, n);
        #1;
        spd_up = 1'b1; spd_dn = 1'b1;
        wait_step(80, n);
        check("both_period", n, 22);
        check("both_speed", int'(speed), 5);
        #1;
        spd_up = 1'b0; spd_dn = 1'b0;
        cycles(3);

        // Held button: one change, on the third edge after the rise.
        #1 spd_up = 1'b1;
        @(negedge clk); check("held_e1", int'(speed), 5);
        @(negedge clk); check("held_e2", int'(speed), 5);
        @(negedge clk); check("held_e3", int'(speed), 6);
        cycles(100);
        check("held_100", int'(speed), 6);
        #1 spd_up = 1'b0;

        // Enable freeze at pos 2 going up; period is 20 cycles at speed 6.
        wait_pos(2, 0, 400);
        cycles(5); #1;
        en = 1'b0;
        cycles(50);
        check("freeze_pos", int'(pos), 2);
        check("freeze_dir", int'(dir), 0);
        check("freeze_ledr", int'(LEDR), 4);
        #1 en = 1'b1;
        wait_step(40, n);
        check("resume_remaining", n, 15);
        check("resume_pos", int'(pos), 3);
        check("resume_dir", int'(dir), 1);

        // Reset mid-sweep while moving down.
        wait_pos(2, 1, 400);
        cycles(5);
        async_reset("rst_mid");

        // Random enable, button and reset activity against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) spd_up = ~spd_up;
            if ($urandom_range(0, 5) == 0) spd_dn = ~spd_dn;
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk); #1;
        rst = 1'b0; en = 1'b0; spd_up = 1'b0; spd_dn = 1'b0;
        cycles(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/supercar_scanner.md
Name: supercar_scanner

Overview:
Sequential core of the Supercar light bar: a bouncing one-hot LED pattern with a user-adjustable sweep speed.
Sits directly upstream of the 7-segment decoders. Its 4-bit pos and speed nibbles drive one BCD_7Seg instance each (HEX0 = position, HEX1 = speed).
LEDR drives the board LEDs directly.

Parameters:
N_LEDS, 10, number of LEDs in the bar; legal range 2..16.
TICK_DIV, 2_500_000, CLOCK_50 cycles per base tick; minimum 1.
SPEED_INIT, 8, speed level loaded at reset; range 0..15.

Ports:
CLOCK_50  in   1       system clock; all state is on the rising edge.
rst       in   1       asynchronous, active-high reset.
en        in   1       run enable; 0 freezes the sweep.
spd_up    in   1       active-high button level, asynchronous to CLOCK_50; each rising edge means speed +1.
spd_dn    in   1       active-high button level, asynchronous to CLOCK_50; each rising edge means speed -1.
LEDR      out  N_LEDS  one-hot LED pattern; bit pos is lit.
pos       out  4       current LED index, zero-extended, 0..N_LEDS-1; feeds BCD_7Seg.
speed     out  4       current speed level 0..15; feeds BCD_7Seg.
dir       out  1       0 = moving toward higher index, 1 = moving toward lower index.
step      out  1       one-cycle pulse on the cycle pos/LEDR update.

Behaviour:
- Clocking and reset: one clock, CLOCK_50. rst is asynchronous and active-high; its assertion takes effect immediately, with no clock edge required.
- Reset values: pos=0, LEDR=1 (bit 0 lit), dir=0, speed=SPEED_INIT, step=0; all counters and synchroniser flops are 0.
- Registered outputs: every output is a flop; no output has a combinational path from any input.
- Base prescaler:
  - base_cnt counts 0..TICK_DIV-1 while en=1.
  - base_tick is asserted when base_cnt==TICK_DIV-1; base_cnt then wraps to 0.
- Step counter:
  - step_cnt increments on each base_tick.
  - When step_cnt reaches 16-speed base ticks, step_cnt wraps to 0 and a step occurs.
  - Step period is therefore (16-speed)*TICK_DIV cycles: 16*TICK_DIV at speed 0, 1*TICK_DIV at speed 15.
- Step action:
  - next = dir ? pos-1 : pos+1.
  - pos<=next; LEDR<=1<<next; step=1 for exactly that cycle.
  - If next==N_LEDS-1 or next==0, dir toggles on the same edge.
  - Resulting sequence: 0,1,..,N-1,N-2,..,0,1,... Each endpoint is shown for one period only; there is no double dwell.
- Enable:
  - en=0 holds base_cnt, step_cnt, pos, LEDR and dir; step stays 0.
  - When en returns to 1, counting resumes from the held counts; there is no restart.
- Buttons:
  - Each button passes through a 2-flop synchroniser, then a rising-edge detector (sub-module).
  - The speed register updates on the 3rd rising CLOCK_50 edge after the input rises.
  - spd_up edge: speed+1, saturating at 15. spd_dn edge: speed-1, saturating at 0.
  - Edges on both buttons in the same cycle: speed unchanged.
  - Speed changes are accepted even when en=0.
  - Any effective speed change (value actually changes) clears step_cnt to 0; base_cnt is not cleared.
  - A held button produces exactly one change.
- Width rules: pos is 4 bits for all N_LEDS≤16, and unused upper LEDR bits do not exist. The speed limit arithmetic is done at 5 bits (16-speed, range 1..16).
- Reset mid-operation: async clear to the reset values at any point, including mid-step and mid-synchroniser. The first step after reset release occurs after a full period at SPEED_INIT.

Decomposition:
- Package supercar_pkg holds SPEED_W=4, SPEED_MAX=15, POS_W=4, and the function speed_limit(speed) = 16-speed.
- Sub-module button_edge: 2-flop synchroniser plus rising-edge pulse. It uses the same CLOCK_50/rst, with reset to 0. It is instantiated twice, once for spd_up and once for spd_dn.

Test Plan:
- Bench settings for all scenarios: N_LEDS=4, TICK_DIV=2.
- Reset: assert rst between edges -> LEDR=0001, pos=0, dir=0, speed=8, step=0 immediately; first step 16 cycles after release.
- Sweep: raise speed to 14 (period 4 cycles), en=1 -> pos 0,1,2,3,2,1,0,1 every 4 cycles; dir=1 from the step reaching 3, dir=0 from the step reaching 0; LEDR 0001,0010,0100,1000,0100,...; step is high one cycle per move.
- Saturation: 10 separate spd_up presses from 8 -> speed=15, step period 2 cycles; then 20 spd_dn presses -> speed=0, step period 32 cycles.
- Simultaneous buttons: spd_up and spd_dn rise on the same edge -> speed unchanged, step_cnt not cleared; a held spd_up for 100 cycles -> speed +1 once, 3 edges after the rise.
- Enable freeze: en=0 at pos=2 with dir=0 for 50 cycles -> outputs constant, step=0; en=1 -> next step after the remaining count, pos=3, dir=1.
- Async reset mid-sweep: rst pulse at pos=2 with dir=1, mid-period -> outputs reset with no clock edge; speed returns to 8.
